// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch stage: owns the PC, issues sequential word
// fetches on a req/gnt/rvalid bus, buffers returned words in an in-order
// circular queue and presents them to decode with a valid/ready handshake.
// A jump from ex flushes the queue and marks every in-flight response as
// stale so it is dropped when it eventually returns.
module if_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_jump_flag_i,
  input  logic [31:0] ex_jump_addr_i,
  output logic        req_o,
  output logic [31:0] req_addr_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] QDEPTH_W = (CW+1)'(QDEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] discard;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   q_inst [QDEPTH];
  logic [31:0]   q_addr [QDEPTH];

  logic [CW:0]   credit_used;
  logic          credit_ok;
  logic          grant;
  logic          head_valid;
  logic          pop;
  logic          drop;
  logic          push;
  logic [31:0]   jump_target;

  // Masking instead of slicing keeps the ignored low bits of the target in use.
  assign jump_target = ex_jump_addr_i & ~32'h0000_0003;

  // A request is only issued while every queue slot is either free or not yet
  // claimed by an in-flight fetch, so a returning word always has room.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign credit_ok   = credit_used < QDEPTH_W;
  assign req_o       = rst & credit_ok;
  assign req_addr_o  = fetch_pc;
  assign grant       = req_o & gnt_i;

  assign head_valid  = (count != '0);
  assign pop         = head_valid & inst_ready_i;
  assign drop        = rvalid_i & (discard != '0);
  assign push        = rvalid_i & (discard == '0) & ~ex_jump_flag_i;

  assign inst_valid_o = head_valid;
  assign inst_o       = head_valid ? q_inst[rd_ptr] : NOP_INST;
  assign inst_addr_o  = head_valid ? q_addr[rd_ptr] : 32'h0000_0000;

  // In-flight request count after this cycle's grant and response.
  always_comb begin
    outstanding_nxt = outstanding;
    if (grant && !rvalid_i) begin
      outstanding_nxt = outstanding + CW'(1);
    end else if (!grant && rvalid_i && (outstanding != '0)) begin
      outstanding_nxt = outstanding - CW'(1);
    end
  end

  // Queue occupancy after this cycle's push/pop; a jump empties it outright.
  always_comb begin
    count_nxt = count;
    if (ex_jump_flag_i) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Fetch PC and the address tag for the next accepted response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (ex_jump_flag_i) begin
      fetch_pc <= jump_target;
      resp_pc  <= jump_target;
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
      end
    end
  end

  // In-flight and stale-response bookkeeping. On a jump every request still
  // in flight after this cycle (including one granted now) belongs to the
  // old stream, which is exactly the next outstanding count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (ex_jump_flag_i) begin
        discard <= outstanding_nxt;
      end else if (drop) begin
        discard <= discard - CW'(1);
      end
    end
  end

  // Queue pointers and occupancy; pointer wrap relies on QDEPTH being a power of 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count_nxt;
      if (ex_jump_flag_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

  // Queue storage: instruction word plus the address it was fetched from.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        q_inst[i] <= '0;
        q_addr[i] <= '0;
      end
    end else if (push) begin
      q_inst[wr_ptr] <= rdata_i;
      q_addr[wr_ptr] <= resp_pc;
    end
  end

endmodule
